// File: rtl/eth_tx_mmio_pkg.sv
// Shared types and default MMIO register offsets for the Ethernet TX MMIO initiator.
// The offsets match the ones used by ethernet_memory_map.
package eth_tx_mmio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_POLL      = 3'd1,
        ST_POLL_WAIT = 3'd2,
        ST_DATA      = 3'd3,
        ST_SIZE      = 3'd4,
        ST_SEND      = 3'd5,
        ST_DROP      = 3'd6
    } tx_state_e;

    localparam logic [13:0] TX_STATUS_ADDR_DEF = 14'h0808;
    localparam logic [13:0] TX_SEND_ADDR_DEF   = 14'h0810;
    localparam logic [13:0] TX_SIZE_ADDR_DEF   = 14'h0818;
    localparam logic [13:0] TX_BUF_BASE_DEF    = 14'h1000;

endpackage

// File: rtl/eth_tx_mmio_initiator_chk.sv
// Protocol checks for eth_tx_mmio_initiator: stream word width rule and
// mutually exclusive MMIO strobes.
module eth_tx_mmio_initiator_chk #(
    parameter int data_width_p = 32
) (
    input logic                            clk_i,
    input logic                            reset_n_i,
    input logic                            s_valid_i,
    input logic                            s_ready_i,
    input logic                            s_last_i,
    input logic [$clog2(data_width_p/8):0] s_bytes_i,
    input logic                            write_en_i,
    input logic                            read_en_i
);

    localparam int bpw_lp = data_width_p / 8;

    // Only the final word of a frame may be partial.
    a_full_word_unless_last: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (s_valid_i && s_ready_i && !s_last_i) |-> (int'(s_bytes_i) == bpw_lp));

    // The controller port never sees a read and a write together.
    a_strobe_exclusive: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(write_en_i && read_en_i));

endmodule

// File: rtl/eth_tx_mmio_initiator.sv
// Drives the Ethernet controller MMIO slave port from a frame word stream:
// poll TX-ready, copy the frame into the TX buffer, write length, strobe send.
module eth_tx_mmio_initiator
    import eth_tx_mmio_pkg::*;
#(
    parameter int          data_width_p     = 32,
    parameter int          eth_mtu_p        = 2048,
    parameter logic [13:0] tx_status_addr_p = TX_STATUS_ADDR_DEF,
    parameter logic [13:0] tx_send_addr_p   = TX_SEND_ADDR_DEF,
    parameter logic [13:0] tx_size_addr_p   = TX_SIZE_ADDR_DEF,
    parameter logic [13:0] tx_buf_base_p    = TX_BUF_BASE_DEF
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic [data_width_p-1:0]                     s_data_i,
    input  logic [$clog2(data_width_p/8):0]             s_bytes_i,
    input  logic                                        s_last_i,
    input  logic                                        s_valid_i,
    output logic                                        s_ready_o,
    output logic [13:0]                                 addr_o,
    output logic                                        write_en_o,
    output logic                                        read_en_o,
    output logic [$clog2($clog2(data_width_p/8)+1)-1:0] op_size_o,
    output logic [data_width_p-1:0]                     write_data_o,
    input  logic [data_width_p-1:0]                     read_data_i,
    output logic                                        busy_o,
    output logic                                        sent_o,
    output logic                                        drop_o
);

    localparam int bpw_lp     = data_width_p / 8;
    localparam int lg_bpw_lp  = $clog2(bpw_lp);
    localparam int bytes_w_lp = lg_bpw_lp + 1;
    localparam int op_w_lp    = $clog2(lg_bpw_lp + 1);
    localparam int cnt_w_lp   = $clog2(eth_mtu_p + 1);
    localparam int sum_w_lp   = cnt_w_lp + 1;
    localparam int idx_w_lp   = 14 - lg_bpw_lp;

    tx_state_e               state_r, state_s;
    logic [cnt_w_lp-1:0]     byte_cnt_r, byte_cnt_s;
    logic [idx_w_lp-1:0]     word_idx_r, word_idx_s;
    logic                    ovf_r, ovf_s;

    logic                    wr_s, rd_s, sent_s, drop_s;
    logic [13:0]             addr_s;
    logic [data_width_p-1:0] wdata_s;

    logic [bytes_w_lp-1:0]   eff_bytes_s;
    logic [sum_w_lp-1:0]     sum_s;
    logic                    over_s;
    logic                    unused_rdata_s;

    // Only the ready bit of the status word matters.
    assign unused_rdata_s = ^read_data_i[data_width_p-1:1];

    // A non-final word is always treated as a full word, whatever s_bytes_i says.
    assign eff_bytes_s = s_last_i ? s_bytes_i : bytes_w_lp'(bpw_lp);
    assign sum_s       = {1'b0, byte_cnt_r} + sum_w_lp'(eff_bytes_s);
    assign over_s      = ovf_r || (sum_s > sum_w_lp'(eth_mtu_p));

    assign s_ready_o = (state_r == ST_DATA);
    assign busy_o    = (state_r != ST_IDLE);

    // Next-state, counter and next-bus-op decode.
    always_comb begin
        state_s    = state_r;
        byte_cnt_s = byte_cnt_r;
        word_idx_s = word_idx_r;
        ovf_s      = ovf_r;
        wr_s       = 1'b0;
        rd_s       = 1'b0;
        sent_s     = 1'b0;
        drop_s     = 1'b0;
        addr_s     = 14'h0000;
        wdata_s    = {data_width_p{1'b0}};
        case (state_r)
            // The status read is launched on entry so read data lands in POLL_WAIT.
            ST_IDLE: begin
                if (s_valid_i) begin
                    state_s = ST_POLL;
                    rd_s    = 1'b1;
                    addr_s  = tx_status_addr_p;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_POLL: begin
                state_s = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (read_data_i[0]) begin
                    state_s    = ST_DATA;
                    byte_cnt_s = {cnt_w_lp{1'b0}};
                    word_idx_s = {idx_w_lp{1'b0}};
                    ovf_s      = 1'b0;
                end else begin
                    state_s = ST_POLL;
                    rd_s    = 1'b1;
                    addr_s  = tx_status_addr_p;
                end
            end
            ST_DATA: begin
                if (s_valid_i) begin
                    // Once oversize, keep draining but stop writing so the buffer never wraps.
                    if (!over_s) begin
                        wr_s       = 1'b1;
                        addr_s     = tx_buf_base_p + {word_idx_r, {lg_bpw_lp{1'b0}}};
                        wdata_s    = s_data_i;
                        byte_cnt_s = sum_s[cnt_w_lp-1:0];
                        word_idx_s = word_idx_r + idx_w_lp'(1);
                    end else begin
                        ovf_s = 1'b1;
                    end
                    if (s_last_i) begin
                        state_s = over_s ? ST_DROP : ST_SIZE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_SIZE: begin
                state_s = ST_SEND;
                wr_s    = 1'b1;
                addr_s  = tx_size_addr_p;
                wdata_s = data_width_p'(byte_cnt_r);
            end
            ST_SEND: begin
                state_s = ST_IDLE;
                wr_s    = 1'b1;
                sent_s  = 1'b1;
                addr_s  = tx_send_addr_p;
                wdata_s = {{(data_width_p-1){1'b0}}, 1'b1};
            end
            ST_DROP: begin
                state_s = ST_IDLE;
                drop_s  = 1'b1;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and frame counters.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= {cnt_w_lp{1'b0}};
            word_idx_r <= {idx_w_lp{1'b0}};
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            byte_cnt_r <= byte_cnt_s;
            word_idx_r <= word_idx_s;
            ovf_r      <= ovf_s;
        end
    end

    // Registered MMIO port and event pulses.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_o       <= 14'h0000;
            write_en_o   <= 1'b0;
            read_en_o    <= 1'b0;
            op_size_o    <= {op_w_lp{1'b0}};
            write_data_o <= {data_width_p{1'b0}};
            sent_o       <= 1'b0;
            drop_o       <= 1'b0;
        end else begin
            addr_o       <= addr_s;
            write_en_o   <= wr_s;
            read_en_o    <= rd_s;
            op_size_o    <= (wr_s || rd_s) ? op_w_lp'(lg_bpw_lp) : {op_w_lp{1'b0}};
            write_data_o <= wdata_s;
            sent_o       <= sent_s;
            drop_o       <= drop_s;
        end
    end

endmodule

// File: tb/tb_eth_tx_mmio_initiator.sv
// Scoreboard bench for eth_tx_mmio_initiator: expected MMIO ops are queued per
// frame and matched against the bus as the DUT issues them.
module tb_eth_tx_mmio_initiator;

    localparam int DW = 32;

    typedef struct packed {
        logic        wr;
        logic [13:0] addr;
        logic [31:0] data;
    } op_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] s_data;
    logic [2:0]    s_bytes;
    logic          s_last, s_valid, s_ready;
    logic [13:0]   addr;
    logic          write_en, read_en;
    logic [1:0]    op_size;
    logic [DW-1:0] write_data, read_data;
    logic          busy, sent, drop;

    op_t         exp_q[$];
    int          status_q[$];
    int          rd_cycles[$];
    logic [31:0] wd[$];
    int          wb[$];
    bit          wl[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          sent_cnt = 0;
    int          drop_cnt = 0;
    int          last_buf_cyc, send_cyc;
    int          first_ready_cyc = -1;
    bit          pend_v = 1'b0;
    logic [31:0] pend_d;
    int          s0, d0;

    always #5 clk = ~clk;

    eth_tx_mmio_initiator #(.data_width_p(DW)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .s_data_i(s_data), .s_bytes_i(s_bytes), .s_last_i(s_last),
        .s_valid_i(s_valid), .s_ready_o(s_ready),
        .addr_o(addr), .write_en_o(write_en), .read_en_o(read_en),
        .op_size_o(op_size), .write_data_o(write_data), .read_data_i(read_data),
        .busy_o(busy), .sent_o(sent), .drop_o(drop)
    );

    eth_tx_mmio_initiator_chk #(.data_width_p(DW)) chk (
        .clk_i(clk), .reset_n_i(reset_n), .s_valid_i(s_valid), .s_ready_i(s_ready),
        .s_last_i(s_last), .s_bytes_i(s_bytes), .write_en_i(write_en), .read_en_i(read_en)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_op(input bit wr, input logic [13:0] a, input logic [31:0] d);
        op_t o;
        o.wr = wr; o.addr = a; o.data = d;
        exp_q.push_back(o);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model (registered status read) and bus monitor.
    always @(negedge clk) begin
        op_t e;
        read_data = pend_v ? pend_d : 32'h0;
        pend_v = 1'b0;
        if (read_en) begin
            pend_v = 1'b1;
            pend_d = (status_q.size() != 0) ? 32'(status_q.pop_front()) : 32'h1;
            rd_cycles.push_back(cyc);
        end
        if (s_ready && first_ready_cyc < 0) first_ready_cyc = cyc;
        if (write_en || read_en) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_op", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_eq("op_kind", write_en, e.wr);
                check_eq("op_addr", addr, e.addr);
                if (e.wr) check_eq("op_data", write_data, e.data);
                check_eq("op_size", op_size, 2);
                if (e.wr && e.addr == 14'h0810) check_eq("sent_with_send", sent, 1);
            end
            if (write_en && addr >= 14'h1000) last_buf_cyc = cyc;
            if (write_en && addr == 14'h0810) send_cyc = cyc;
        end
        if (sent) sent_cnt++;
        if (drop) drop_cnt++;
    end

    task automatic prep_frame(input int nbytes, input int zeros);
        int nw, acc, b;
        wd.delete(); wb.delete(); wl.delete();
        rd_cycles.delete();
        first_ready_cyc = -1;
        for (int z = 0; z < zeros; z++) begin
            status_q.push_back(0);
            push_op(1'b0, 14'h0808, 32'h0);
        end
        status_q.push_back(1);
        push_op(1'b0, 14'h0808, 32'h0);
        nw  = (nbytes + 3) / 4;
        acc = 0;
        for (int i = 0; i < nw; i++) begin
            b = (i == nw - 1) ? nbytes - 4 * i : 4;
            wd.push_back($urandom);
            wb.push_back(b);
            wl.push_back(i == nw - 1);
            acc += b;
            if (acc <= 2048) push_op(1'b1, 14'(14'h1000 + 4 * i), wd[i]);
        end
        if (nbytes <= 2048) begin
            push_op(1'b1, 14'h0818, 32'(nbytes));
            push_op(1'b1, 14'h0810, 32'h1);
        end
    endtask

    task automatic drive_words(input int first, input int cnt, input bit bubbles);
        bit ok;
        int budget;
        for (int w = first; w < first + cnt; w++) begin
            if (bubbles) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            s_valid = 1'b1;
            s_data  = wd[w];
            s_bytes = 3'(wb[w]);
            s_last  = wl[w];
            ok = 1'b0;
            budget = 0;
            while (!ok && budget < 200) begin
                @(negedge clk);
                ok = s_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!ok) check_eq("handshake_timeout", budget, 0);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int b = 0;
        while ((exp_q.size() != 0 || busy) && b < 300) begin
            @(negedge clk);
            b++;
        end
        repeat (2) @(negedge clk);
        check_eq("frame_done_pending_ops", exp_q.size(), 0);
        check_eq("frame_done_busy", busy, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        s_data = 32'h0; s_bytes = 3'd0; s_last = 1'b0; s_valid = 1'b0;
        read_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_write_en", write_en, 0);
        check_eq("rst_read_en", read_en, 0);
        check_eq("rst_addr", addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", s_ready, 0);
        check_eq("rst_sent_drop", {sent, drop}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 64-byte frame, no bubbles
        s0 = sent_cnt;
        prep_frame(64, 0);
        drive_words(0, 16, 1'b0);
        wait_done();
        check_eq("t1_sent_count", sent_cnt - s0, 1);
        check_eq("t1_last_data_to_send", send_cyc - last_buf_cyc, 2);

        // 61-byte frame, partial last word
        prep_frame(61, 0);
        drive_words(0, 16, 1'b0);
        wait_done();

        // status not ready three times
        prep_frame(8, 3);
        drive_words(0, 2, 1'b0);
        wait_done();
        check_eq("t3_poll_count", rd_cycles.size(), 4);
        if (rd_cycles.size() == 4) begin
            for (int i = 1; i < 4; i++) check_eq("t3_poll_spacing", rd_cycles[i] - rd_cycles[i-1], 2);
            check_eq("t3_ready_after_4th_read", first_ready_cyc - rd_cycles[3], 2);
        end

        // oversize frame
        s0 = sent_cnt; d0 = drop_cnt;
        prep_frame(2052, 0);
        drive_words(0, 513, 1'b0);
        wait_done();
        check_eq("t4_drop_count", drop_cnt - d0, 1);
        check_eq("t4_no_send", sent_cnt - s0, 0);

        // reset in the middle of a frame
        s0 = sent_cnt;
        prep_frame(64, 0);
        drive_words(0, 5, 1'b0);
        reset_n = 1'b0;
        #1;
        check_eq("t5_write_en_in_reset", write_en, 0);
        check_eq("t5_busy_in_reset", busy, 0);
        repeat (2) @(posedge clk);
        exp_q.delete();
        status_q.delete();
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("t5_no_send_after_abort", sent_cnt - s0, 0);
        prep_frame(8, 0);
        drive_words(0, 2, 1'b0);
        wait_done();

        // two back-to-back 8-byte frames with bubbles
        s0 = sent_cnt;
        prep_frame(8, 0);
        drive_words(0, 2, 1'b1);
        prep_frame(8, 0);
        drive_words(0, 2, 1'b1);
        wait_done();
        check_eq("t6_sent_count", sent_cnt - s0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
